// File: rtl/vram_if.sv
// Requester, store and frame-RAM signals shared between the VGA fetcher, vector memory stage and vram_arbiter.
// master = requesters plus RAM model side, slave = arbiter side.
interface vram_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_gnt;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_rvalid;

  logic                st_req;
  logic [ADDR_W-1:0]   st_addr;
  logic [DATA_W-1:0]   st_wdata;
  logic [DATA_W/8-1:0] st_be;
  logic                st_gnt;

  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    output vga_req, vga_addr, ld_req, ld_addr, st_req, st_addr, st_wdata, st_be, mem_rdata,
    input  vga_gnt, vga_rdata, vga_rvalid, ld_gnt, ld_rdata, ld_rvalid, st_gnt,
           mem_addr, mem_we, mem_be, mem_wdata
  );

  modport slave (
    input  vga_req, vga_addr, ld_req, ld_addr, st_req, st_addr, st_wdata, st_be, mem_rdata,
    output vga_gnt, vga_rdata, vga_rvalid, ld_gnt, ld_rdata, ld_rvalid, st_gnt,
           mem_addr, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares the single-port frame RAM: VGA has priority, a starvation counter forces a processor slot,
// load/store alternate round-robin. Grants are combinational; RAM access at N+1, rvalid at N+2.
module vram_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input logic  clk,
  input logic  rst,
  vram_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  typedef enum logic { RR_LD = 1'b0, RR_ST = 1'b1 } rr_t;
  typedef enum logic [1:0] { TAG_NONE = 2'd0, TAG_VGA = 2'd1, TAG_LD = 2'd2 } tag_t;

  rr_t               rr_last;
  tag_t              tag_q1;
  tag_t              tag_q2;
  logic [7:0]        starve_cnt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic proc_req;
  logic forced;
  logic pick_ld;
  logic vga_gnt_c;
  logic ld_gnt_c;
  logic st_gnt_c;

  assign proc_req = bus.ld_req | bus.st_req;
  assign forced   = (starve_cnt == STARVE_LIM) && proc_req;
  // Load wins when alone or when store was the last processor grant.
  assign pick_ld  = bus.ld_req && (!bus.st_req || rr_last == RR_ST);

  always_comb begin
    vga_gnt_c = 1'b0;
    ld_gnt_c  = 1'b0;
    st_gnt_c  = 1'b0;
    if (!rst) begin
      if (!forced && bus.vga_req) begin
        vga_gnt_c = 1'b1;
      end else begin
        ld_gnt_c = pick_ld;
        st_gnt_c = bus.st_req && !pick_ld;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last     <= RR_ST;
      starve_cnt  <= 8'd0;
      tag_q1      <= TAG_NONE;
      tag_q2      <= TAG_NONE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (ld_gnt_c) begin
        rr_last <= RR_LD;
      end else if (st_gnt_c) begin
        rr_last <= RR_ST;
      end

      if (ld_gnt_c || st_gnt_c) begin
        starve_cnt <= 8'd0;
      end else if (vga_gnt_c && proc_req && starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 8'd1;
      end

      tag_q2 <= tag_q1;
      tag_q1 <= vga_gnt_c ? TAG_VGA : (ld_gnt_c ? TAG_LD : TAG_NONE);

      mem_we_q <= st_gnt_c;
      mem_be_q <= st_gnt_c ? bus.st_be : '0;
      if (vga_gnt_c) begin
        mem_addr_q <= bus.vga_addr;
      end else if (ld_gnt_c) begin
        mem_addr_q <= bus.ld_addr;
      end else if (st_gnt_c) begin
        mem_addr_q  <= bus.st_addr;
        mem_wdata_q <= bus.st_wdata;
      end
    end
  end

  assign bus.vga_gnt    = vga_gnt_c;
  assign bus.ld_gnt     = ld_gnt_c;
  assign bus.st_gnt     = st_gnt_c;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.vga_rvalid = (tag_q2 == TAG_VGA);
  assign bus.ld_rvalid  = (tag_q2 == TAG_LD);
  assign bus.vga_rdata  = bus.mem_rdata;
  assign bus.ld_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model with 1-cycle read latency, read-return scoreboard, per-feature tasks.
module tb_vram_arbiter;
  localparam int AW = 17;
  localparam int DW = 32;
  localparam int SM = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] ram    [0:255];
  logic [31:0] shadow [0:255];
  logic        pre_we   = 1'b0;
  logic [7:0]  pre_addr = 8'd0;
  logic [31:0] pre_dat  = 32'd0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_dat;
    if (bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) ram[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    bus.mem_rdata <= ram[bus.mem_addr[7:0]];
  end

  typedef struct packed {
    logic        is_ld;
    logic [31:0] dat;
  } exp_t;

  exp_t sbq[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard consumer: every returned read must match the oldest expected one.
  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (!rst && (bus.vga_rvalid || bus.ld_rvalid)) begin
      n_checks++;
      if (bus.vga_rvalid && bus.ld_rvalid) begin
        n_fail++;
        $display("FAIL sb_both_rvalid: vga_rvalid=%b ld_rvalid=%b, required one at a time", bus.vga_rvalid, bus.ld_rvalid);
      end else if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_rvalid: vga_rvalid=%b ld_rvalid=%b with no read outstanding", bus.vga_rvalid, bus.ld_rvalid);
      end else begin
        e = sbq.pop_front();
        if (bus.ld_rvalid !== e.is_ld || bus.mem_rdata !== e.dat) begin
          n_fail++;
          $display("FAIL sb_read_return: got ld=%b data=%h, expected ld=%b data=%h", bus.ld_rvalid, bus.mem_rdata, e.is_ld, e.dat);
        end
      end
    end
  end

  task automatic drop_reqs();
    bus.vga_req = 1'b0;
    bus.ld_req  = 1'b0;
    bus.st_req  = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    drop_reqs();
    bus.vga_addr = '0; bus.ld_addr = '0; bus.st_addr = '0;
    bus.st_wdata = '0; bus.st_be = '0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      v = (i == 'h10) ? 32'hDEADBEEF : (i == 'h20) ? 32'hAABBCCDD : (32'hC0DE0000 | 32'(i));
      pre_we = 1'b1; pre_addr = 8'(i); pre_dat = v; shadow[i] = v;
    end
    @(negedge clk);
    pre_we = 1'b0;
    bus.vga_req = 1'b1; bus.ld_req = 1'b1; bus.st_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({bus.vga_gnt, bus.ld_gnt, bus.st_gnt} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_gnt: cycle %0d gnt=%b expected 000", i, {bus.vga_gnt, bus.ld_gnt, bus.st_gnt});
      end
      n_checks++;
      if ({bus.mem_we, bus.vga_rvalid, bus.ld_rvalid} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_we_rvalid: cycle %0d we/vrv/lrv=%b expected 000", i, {bus.mem_we, bus.vga_rvalid, bus.ld_rvalid});
      end
    end
    n_checks++;
    if (bus.mem_addr !== '0 || bus.mem_be !== '0 || bus.mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mem_regs: addr=%h be=%b wdata=%h expected all zero", bus.mem_addr, bus.mem_be, bus.mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.vga_gnt, bus.ld_gnt, bus.st_gnt} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release_gnt: gnt=%b expected 100", {bus.vga_gnt, bus.ld_gnt, bus.st_gnt});
    end
    sbq.push_back('{is_ld: 1'b0, dat: shadow[0]});
    @(negedge clk);
    drop_reqs();
    #1;
    n_checks++;
    if ({bus.vga_gnt, bus.ld_gnt, bus.st_gnt} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_no_gnt: gnt=%b expected 000", {bus.vga_gnt, bus.ld_gnt, bus.st_gnt});
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic ld_turn = 1'b1;
    bus.ld_addr = 17'h00030; bus.st_addr = 17'h00040;
    bus.st_wdata = 32'h55; bus.st_be = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.ld_req = 1'b1; bus.st_req = 1'b1;
      #1;
      n_checks++;
      if (bus.ld_gnt !== ld_turn || bus.st_gnt !== !ld_turn || bus.vga_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_order: grant %0d ld/st=%b%b expected %b%b", i, bus.ld_gnt, bus.st_gnt, ld_turn, !ld_turn);
      end
      if (ld_turn) sbq.push_back('{is_ld: 1'b1, dat: shadow['h30]});
      ld_turn = !ld_turn;
    end
    @(negedge clk);
    drop_reqs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_load();
    @(negedge clk);
    bus.ld_req = 1'b1; bus.ld_addr = 17'h00010;
    #1;
    n_checks++;
    if ({bus.vga_gnt, bus.ld_gnt, bus.st_gnt} !== 3'b010) begin
      n_fail++;
      $display("FAIL load_gnt: gnt=%b expected 010", {bus.vga_gnt, bus.ld_gnt, bus.st_gnt});
    end
    sbq.push_back('{is_ld: 1'b1, dat: 32'hDEADBEEF});
    @(negedge clk);
    n_checks++;
    if (bus.mem_addr !== 17'h00010 || bus.mem_we !== 1'b0 || bus.ld_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_mem_addr: addr=%h we=%b rvalid=%b expected 00010 0 0", bus.mem_addr, bus.mem_we, bus.ld_rvalid);
    end
    bus.ld_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.ld_rvalid !== 1'b1 || bus.ld_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load_return: rvalid=%b rdata=%h expected 1 deadbeef", bus.ld_rvalid, bus.ld_rdata);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_starvation();
    logic exp_ld;
    bus.vga_addr = 17'h00050; bus.ld_addr = 17'h00060;
    for (int i = 0; i < 2 * (SM + 1); i++) begin
      @(negedge clk);
      bus.vga_req = 1'b1; bus.ld_req = 1'b1;
      #1;
      exp_ld = (i % (SM + 1)) == SM;
      n_checks++;
      if ({bus.vga_gnt, bus.ld_gnt, bus.st_gnt} !== {!exp_ld, exp_ld, 1'b0}) begin
        n_fail++;
        $display("FAIL starve_order: cycle %0d gnt=%b expected %b", i, {bus.vga_gnt, bus.ld_gnt, bus.st_gnt}, {!exp_ld, exp_ld, 1'b0});
      end
      sbq.push_back('{is_ld: exp_ld, dat: exp_ld ? shadow['h60] : shadow['h50]});
    end
    @(negedge clk);
    drop_reqs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_store_load();
    @(negedge clk);
    bus.st_req = 1'b1; bus.st_addr = 17'h00020;
    bus.st_wdata = 32'h11223344; bus.st_be = 4'b0101;
    #1;
    n_checks++;
    if ({bus.vga_gnt, bus.ld_gnt, bus.st_gnt} !== 3'b001) begin
      n_fail++;
      $display("FAIL store_gnt: gnt=%b expected 001", {bus.vga_gnt, bus.ld_gnt, bus.st_gnt});
    end
    @(negedge clk);
    n_checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_be !== 4'b0101 || bus.mem_addr !== 17'h00020 || bus.mem_wdata !== 32'h11223344) begin
      n_fail++;
      $display("FAIL store_mem_port: we=%b be=%b addr=%h wdata=%h expected 1 0101 00020 11223344",
               bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
    end
    bus.st_req = 1'b0;
    bus.ld_req = 1'b1; bus.ld_addr = 17'h00020;
    #1;
    n_checks++;
    if (bus.ld_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL store_load_gnt: ld_gnt=%b expected 1", bus.ld_gnt);
    end
    shadow['h20] = 32'hAA22CC44;
    sbq.push_back('{is_ld: 1'b1, dat: 32'hAA22CC44});
    @(negedge clk);
    n_checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'b0000) begin
      n_fail++;
      $display("FAIL store_we_clear: we=%b be=%b expected 0 0000", bus.mem_we, bus.mem_be);
    end
    bus.ld_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_midflight_reset();
    // Store granted, then reset: registered write must be dropped and mem regs cleared.
    @(negedge clk);
    bus.st_req = 1'b1; bus.st_addr = 17'h00070; bus.st_be = 4'b0000; bus.st_wdata = 32'h77;
    #1;
    n_checks++;
    if (bus.st_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_st_gnt: st_gnt=%b expected 1", bus.st_gnt);
    end
    @(negedge clk);
    bus.st_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_be !== '0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL mid_st_reset_regs: we=%b be=%b addr=%h wdata=%h expected all zero",
               bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
    end
    // Load granted, then reset: its read must never return.
    @(negedge clk);
    bus.ld_req = 1'b1; bus.ld_addr = 17'h00010;
    #1;
    n_checks++;
    if (bus.ld_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_ld_gnt: ld_gnt=%b expected 1", bus.ld_gnt);
    end
    @(negedge clk);
    bus.ld_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.ld_rvalid !== 1'b0 || bus.vga_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_ld_dropped: cycle %0d ld_rvalid=%b vga_rvalid=%b expected 0 0", i, bus.ld_rvalid, bus.vga_rvalid);
      end
      if (i < 2) @(negedge clk);
    end
    // Last processor grant was a load, but reset restores rr_last=store so load wins again.
    bus.ld_req = 1'b1; bus.st_req = 1'b1; bus.ld_addr = 17'h00030; bus.st_addr = 17'h00040;
    #1;
    n_checks++;
    if ({bus.ld_gnt, bus.st_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_rr_reset: ld/st=%b expected 10", {bus.ld_gnt, bus.st_gnt});
    end
    sbq.push_back('{is_ld: 1'b1, dat: shadow['h30]});
    @(negedge clk);
    bus.ld_req = 1'b0;
    #1;
    n_checks++;
    if ({bus.ld_gnt, bus.st_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_rr_store: ld/st=%b expected 01", {bus.ld_gnt, bus.st_gnt});
    end
    @(negedge clk);
    drop_reqs();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_load();
    test_starvation();
    test_store_load();
    test_midflight_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: %0d reads outstanding, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
